uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage: recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the asynchronous `rx` line and presents each byte with a ready/clear handshake. It is the counterpart of the UART transmit stage and sits between the external serial line and the byte consumer (FIFO or host bridge). Bit timing comes from a shared baud generator tick at `OVERSAMPLE` times the bit rate.

## Interface
- `OVERSAMPLE`, 16: `clken` ticks per bit period; power of two, ≥ 8.
- `DATA_BITS`, 8: data bits per frame.

- `clock`  in  1  single system clock; all flops on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rx`  in  1  serial line, asynchronous, idle high.
- `clken`  in  1  oversample tick, one `clock` cycle wide, `OVERSAMPLE` × baud.
- `rd_clr`  in  1  consumer acknowledge; clears `rdy`, `overrun` and `frame_err`.
- `data`  out  DATA_BITS  last good byte; held until the next good byte.
- `rdy`  out  1  a byte is valid and unread.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `overrun`  out  1  sticky; a good byte overwrote an unread one.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: `data`=0, `rdy`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0, state=IDLE, synchronizer flops=1.
- `rx` passes through a 2-flop synchronizer. All decisions below use the synchronized value `rxs`.
- The sample counter (log2(OVERSAMPLE) bits) and the bit index (3 bits) advance only on `clken` cycles.
- State machine:
  - **IDLE**: on a `clken` with `rxs`=0, clear the counter and go to START.
  - **START**: at count OVERSAMPLE/2−1 (mid start bit), re-check `rxs`. If 0, clear the counter and bit index, then go to DATA. If 1, the edge was a glitch: go to IDLE with no output change.
  - **DATA**: at count OVERSAMPLE−1, shift `rxs` into bit[index] (LSB first) and wrap the counter. After bit DATA_BITS−1 is sampled, go to STOP.
  - **STOP**: at count OVERSAMPLE−1, sample the stop bit.
    - If `rxs`=1: load `data` from the shift register, set `rdy`, and go to IDLE. If `rdy` was already 1 and `rd_clr` is not asserted in the same cycle, also set `overrun`.
    - If `rxs`=0: set `frame_err`, leave `data` and `rdy` unchanged, and go to BREAK.
  - **BREAK**: wait for a `clken` with `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- `rd_clr` with no concurrent byte completion clears `rdy`, `overrun` and `frame_err` on the next edge.
- `rd_clr` in the same cycle as a good byte completes: the new byte wins. Result is `rdy`=1, `overrun`=0, `frame_err`=0.
- `rd_clr` in the same cycle as a frame error: `frame_err`=1. `rdy` and `overrun` clear.
- Reset asserted mid-frame aborts the frame immediately and returns all outputs to reset values. No partial byte is ever presented.

## Timing
- Synchronizer latency: 2 `clock` cycles from a `rx` change to `rxs`.
- Sampling points: mid start bit, then every OVERSAMPLE ticks, so each data and stop bit is sampled at its centre.
- `rdy`, `data` and `frame_err` update on the `clock` edge after the `clken` cycle that samples the stop bit.
- `rx_busy` rises one cycle after the start-detect tick and falls one cycle after the exit from STOP or BREAK.
- Back-to-back frames: a start bit that begins immediately after the stop-sample tick is detected with no lost frame. The next falling edge is caught on the first following tick.
- Tolerance: sampling stays inside the bit for ±3% baud mismatch at OVERSAMPLE=16.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings STATE_IDLE, STATE_START, STATE_DATA, STATE_STOP, STATE_BREAK, shared with the transmit stage where the names overlap;
  - OVERSAMPLE and DATA_BITS defaults;
  - the derived constants MID_COUNT and LAST_COUNT.
- One sub-module, `uart_rx_sync`: a 2-flop synchronizer with async reset to 1. Everything else stays in `uart_receiver`.

## Test plan
- **Good frame**: frame 0xA5, one bit = 16 ticks → `data`=0xA5, `rdy`=1 one cycle after the stop-sample tick, `frame_err`=0, `overrun`=0. Then `rd_clr` → `rdy`=0.
- **Glitch rejection**: `rx` low for 4 ticks, then high → no state beyond START, `rdy` stays 0, `rx_busy` returns to 0.
- **Framing error**: frame 0x3C with stop bit low, then `rx` held low 40 ticks → `frame_err`=1, `rdy`=0, `data` unchanged. No new frame starts until `rx` goes high. A following 0x81 is received correctly.
- **Overrun**: frames 0x11 then 0x22 with no `rd_clr` → `data`=0x22, `rdy`=1, `overrun`=1. Then `rd_clr` clears both flags.
- **Clear collision**: `rd_clr` pulsed on the completion cycle of 0x7E, with 0x11 unread → `data`=0x7E, `rdy`=1, `overrun`=0.
- **Reset mid-frame**: `reset` pulsed after 4 data bits of 0xFF → all outputs 0, state IDLE. A following 0x5A is received with `data`=0x5A, `rdy`=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants: state encodings, frame defaults and
//                the derived oversample count points.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef logic [2:0] state_t;

  // State encodings, shared with the transmit stage where names overlap
  localparam state_t STATE_IDLE  = 3'd0;
  localparam state_t STATE_START = 3'd1;
  localparam state_t STATE_DATA  = 3'd2;
  localparam state_t STATE_STOP  = 3'd3;
  localparam state_t STATE_BREAK = 3'd4;

  // Frame defaults
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  // Count at the centre of the start bit, and the last count of a bit period
  localparam int MID_COUNT  = DEFAULT_OVERSAMPLE / 2 - 1;
  localparam int LAST_COUNT = DEFAULT_OVERSAMPLE - 1;

  // Same derivations for a non-default oversample ratio
  function automatic int mid_count(input int oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int last_count(input int oversample);
    return oversample - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line.
//                Both flops reset to 1 so an idle line never looks like a
//                start bit coming out of reset.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx_async,
  output logic rx_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state: shift the line through the two stages
  always_comb begin
    meta_d = rx_async;
    sync_d = meta_q;
  end

  // Synchronizer flops, reset to the idle-high level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receive stage. Oversampled start detection with
//                mid-bit glitch check, centre sampling of data and stop bits,
//                ready/clear handshake with sticky overrun and framing error.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 clken,
  input  logic                 rd_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(mid_count(OVERSAMPLE));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(last_count(OVERSAMPLE));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rxs;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q,  data_d;
  logic                   rdy_q,   rdy_d;
  logic                   ferr_q,  ferr_d;
  logic                   ovr_q,   ovr_d;

  uart_rx_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .rx_async (rx),
    .rx_sync  (rxs)
  );

  // Receive state machine and handshake flags; a byte or error completing in
  // the same cycle as rd_clr overrides the clear for the flag it sets.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (rd_clr) begin
      rdy_d  = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if (clken) begin
      case (state_q)
        STATE_IDLE: begin
          if (!rxs) begin
            cnt_d   = '0;
            state_d = STATE_START;
          end
        end

        STATE_START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MID_CNT) begin
            if (!rxs) begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = STATE_DATA;
            end else begin
              state_d = STATE_IDLE;
            end
          end
        end

        STATE_DATA: begin
          // counter wraps naturally at the end of each bit period
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            shift_d[idx_q] = rxs;
            if (idx_q == LAST_IDX) begin
              state_d = STATE_STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        STATE_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            if (rxs) begin
              data_d  = shift_q;
              rdy_d   = 1'b1;
              ovr_d   = ovr_d | (rdy_q & ~rd_clr);
              state_d = STATE_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = STATE_BREAK;
            end
          end
        end

        STATE_BREAK: begin
          // hold off until the line returns high so a stuck-low line
          // does not look like an endless stream of start bits
          if (rxs) begin
            state_d = STATE_IDLE;
          end
        end

        default: begin
          state_d = STATE_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = (state_q != STATE_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Directed self-checking bench for uart_receiver, 16 ticks per
//                bit with one clken tick every four clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

  logic       clock  = 1'b0;
  logic       clken  = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int div    = 0;

  uart_receiver #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .clken     (clken),
    .rd_clr    (rd_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clock = ~clock;

  // Oversample tick: one clock wide, every fourth clock, changed on negedge
  always @(negedge clock) begin
    div   = (div + 1) % 4;
    clken = (div == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return 1ns after the next clock edge that carries a tick
  task automatic wait_tick();
    @(posedge clock);
    while (clken !== 1'b1) @(posedge clock);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  // Start bit plus data bits, LSB first
  task automatic send_head(input logic [7:0] d);
    wait_tick();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_head(d);
    drive_bit(stop_bit);
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    rd_clr = 1'b1;
    @(negedge clock);
    rd_clr = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    rd_clr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_data", data, 8'h00);
    chk("reset_rdy", rdy, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_ovr", overrun, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wait_ticks(4);

    // Good frame 0xA5 with exact completion timing: stop sampled 9 ticks
    // into the stop bit
    send_head(8'hA5);
    rx = 1'b1;
    wait_ticks(8);
    chk("good_rdy_before", rdy, 1'b0);
    chk("good_busy_before", rx_busy, 1'b1);
    wait_tick();
    chk("good_rdy", rdy, 1'b1);
    chk("good_data", data, 8'hA5);
    chk("good_busy_after", rx_busy, 1'b0);
    chk("good_ferr", frame_err, 1'b0);
    chk("good_ovr", overrun, 1'b0);
    wait_ticks(7);
    pulse_clr();
    #1;
    chk("good_clr_rdy", rdy, 1'b0);
    chk("good_clr_data", data, 8'hA5);

    // Glitch: low for 4 ticks only
    wait_tick();
    rx = 1'b0;
    wait_ticks(2);
    chk("glitch_busy_start", rx_busy, 1'b1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(20);
    chk("glitch_busy_end", rx_busy, 1'b0);
    chk("glitch_rdy", rdy, 1'b0);
    chk("glitch_data", data, 8'hA5);

    // Framing error: 0x3C with low stop bit, line held low for 40 more ticks
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    chk("ferr_set", frame_err, 1'b1);
    chk("ferr_rdy", rdy, 1'b0);
    chk("ferr_data", data, 8'hA5);
    chk("ferr_break_busy", rx_busy, 1'b1);
    rx = 1'b1;
    wait_ticks(2);
    chk("ferr_break_exit", rx_busy, 1'b0);
    send_frame(8'h81, 1'b1);
    chk("after_ferr_data", data, 8'h81);
    chk("after_ferr_rdy", rdy, 1'b1);
    chk("after_ferr_sticky", frame_err, 1'b1);
    pulse_clr();
    #1;
    chk("ferr_clr", frame_err, 1'b0);
    chk("ferr_clr_rdy", rdy, 1'b0);

    // Overrun: two bytes, no read in between
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_data", data, 8'h22);
    chk("ovr_rdy", rdy, 1'b1);
    chk("ovr_set", overrun, 1'b1);
    pulse_clr();
    #1;
    chk("ovr_clr_rdy", rdy, 1'b0);
    chk("ovr_clr_ovr", overrun, 1'b0);

    // Clear collision: rd_clr on the exact stop-sample cycle of 0x7E
    send_frame(8'h11, 1'b1);
    chk("coll_pre_rdy", rdy, 1'b1);
    send_head(8'h7E);
    rx = 1'b1;
    wait_ticks(8);
    repeat (3) @(posedge clock);
    #1;
    rd_clr = 1'b1;
    @(posedge clock);
    #1;
    rd_clr = 1'b0;
    chk("coll_data", data, 8'h7E);
    chk("coll_rdy", rdy, 1'b1);
    chk("coll_ovr", overrun, 1'b0);
    chk("coll_ferr", frame_err, 1'b0);
    wait_ticks(7);

    // Reset in the middle of a 0xFF frame
    wait_tick();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    chk("mid_busy", rx_busy, 1'b1);
    reset = 1'b1;
    #2;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_rdy", rdy, 1'b0);
    chk("mid_rst_busy", rx_busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wait_ticks(20);
    chk("mid_idle_busy", rx_busy, 1'b0);
    chk("mid_idle_rdy", rdy, 1'b0);
    send_frame(8'h5A, 1'b1);
    chk("post_rst_data", data, 8'h5A);
    chk("post_rst_rdy", rdy, 1'b1);
    chk("post_rst_ovr", overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
